backscatter_scheduler: RTL and testbench
========================================

BACKSCATTER_SCHEDULER -- requirements
Module: backscatter_scheduler

Interface
REQ-001 Parameter CNT_W, default 16: width of the per-packet cycle counter, which saturates at all-ones.
REQ-002 Parameter WIN_START, default 720: nominal first counter value of the switch window.
REQ-003 Parameter WIN_STOP, default 799: nominal last counter value of the switch window; WIN_STOP > WIN_START + 24 SHALL hold.
REQ-004 CLK  in  1  single clock, 20 MHz (50 ns/count); all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 EN  in  1  enable; low aborts any job.
REQ-007 DEC_IN  in  1  packet envelope from decoder, high while a downlink packet is present.
REQ-008 LOAD_VALID  in  1  job offered.
REQ-009 LOAD_READY  out  1  scheduler can accept a job.
REQ-010 LOAD_DATA  in  16  payload bits, LSB sent first.
REQ-011 LOAD_LEN  in  5  bit count, 0..16; values >16 are treated as 16.
REQ-012 TRIM  in  4  signed sync trim, clamped to -4..+4; effective offset = 3*TRIM counts.
REQ-013 ASW_OUT  out  1  antenna switch drive, registered.
REQ-014 BUSY  out  1  high in every state except IDLE.
REQ-015 BIT_IDX  out  5  index of the bit currently being sent.
REQ-016 DONE  out  1  one-cycle pulse when the last bit has been consumed.
REQ-017 SHORT_PKT  out  1  one-cycle pulse when a packet ends before the window closes.

Function
REQ-018 States: IDLE, WAIT_GAP, WAIT_PKT, IN_PKT.
REQ-019 LOAD_READY SHALL equal (state==IDLE && EN); a transfer occurs on a cycle with LOAD_VALID && LOAD_READY.
REQ-020 On transfer: capture LOAD_DATA and clamped LOAD_LEN, compute ES = WIN_START+3*TRIMc and EE = WIN_STOP+3*TRIMc (held constant for the job), set BIT_IDX=0, go to WAIT_GAP.
REQ-021 A transfer with LEN=0 SHALL go to IDLE instead and pulse DONE on the next cycle.
REQ-022 WAIT_GAP: wait for DEC_IN==0, then go to WAIT_PKT, so that a packet already in progress at load time is never used.
REQ-023 WAIT_PKT: on DEC_IN==1, go to IN_PKT with cnt=1; the first high cycle is defined as cnt value 0.
REQ-024 Counting: cnt = number of earlier DEC_IN-high cycles in this packet; it increments every IN_PKT cycle with DEC_IN==1 and saturates at 2^CNT_W-1.
REQ-025 ASW_OUT next-value SHALL be 1 iff DEC_IN==1 in WAIT_PKT/IN_PKT, current bit==1, and ES <= cnt <= EE; otherwise 0.
REQ-026 Window length SHALL be EE-ES+1 cycles; ASW_OUT first rises on the cycle after the cnt==ES cycle.
REQ-027 IN_PKT with DEC_IN==0 and final cnt > EE: consume the bit.
REQ-028 On consume, if BIT_IDX==LEN-1: pulse DONE and go to IDLE.
REQ-029 On consume otherwise: increment BIT_IDX and go to WAIT_PKT.
REQ-030 IN_PKT with DEC_IN==0 and final cnt <= EE: pulse SHORT_PKT, keep BIT_IDX (the same bit is retried on the next packet), and go to WAIT_PKT.
REQ-031 ASW_OUT SHALL drop on the cycle after DEC_IN falls, including mid-window.
REQ-032 A bit value of 0 SHALL still require a full-length packet in order to be consumed.
REQ-033 EN==0 in any state: next state IDLE, ASW_OUT=0, cnt=0, BIT_IDX=0, no DONE pulse; LOAD_VALID is ignored while EN==0.
REQ-034 DONE and SHORT_PKT SHALL never both be asserted in the same cycle.

Reset
REQ-035 RST==1 SHALL force state=IDLE, ASW_OUT=0, DONE=0, SHORT_PKT=0, BUSY=0, BIT_IDX=0, cnt=0.
REQ-036 Reset SHALL take priority over EN and load; RST mid-packet drops ASW_OUT on the next cycle, and the job is lost.

Verification
REQ-037 Load DATA=0x0005, LEN=3, TRIM=0; three DEC_IN pulses of 900 cycles -> ASW_OUT high for 80 cycles starting 721 cycles after the rise in packets 1 and 3, low in packet 2; DONE pulses once after packet 3 falls.
REQ-038 TRIM=-4, then TRIM=+4 (bit=1) -> window covers counts 708..787, then counts 732..811.
REQ-039 DEC_IN high for 750 cycles (bit=1) -> ASW_OUT asserts at count 720 and drops the cycle after the fall; SHORT_PKT pulses; BIT_IDX is unchanged; the next 900-cycle packet consumes the bit.
REQ-040 Load while DEC_IN is already high -> that packet produces no ASW_OUT; the first bit goes on the following packet.
REQ-041 EN low, or RST high, at count 760 of a '1' bit -> ASW_OUT=0 next cycle, IDLE, LOAD_READY=1 (once EN and !RST), no DONE.
REQ-042 LEN=0 load -> DONE pulses on the next cycle, ASW_OUT stays 0, BUSY never asserts.

Source files
------------

// File: rtl/backscatter_scheduler.sv
// Backscatter bit scheduler: keys the antenna switch inside a counted window of
// each downlink packet envelope, one payload bit per full-length packet.
module backscatter_scheduler #(
  parameter int CNT_W     = 16,
  parameter int WIN_START = 720,
  parameter int WIN_STOP  = 799
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dec_in,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [15:0]       load_data,
  input  logic [4:0]        load_len,
  input  logic signed [3:0] trim,
  output logic              asw_out,
  output logic              busy,
  output logic [4:0]        bit_idx,
  output logic              done,
  output logic              short_pkt
);

  typedef enum logic [1:0] {IDLE, WAIT_GAP, WAIT_PKT, IN_PKT} state_t;

  // Two spare bits let the trimmed window edges go negative without wrapping.
  localparam int WW = CNT_W + 2;

  state_t               state;
  logic [15:0]          data;
  logic [4:0]           len;
  logic [CNT_W-1:0]     cnt;
  logic signed [WW-1:0] es, ee;

  logic [4:0]           len_c;
  logic signed [3:0]    trim_c;
  logic signed [WW-1:0] offset, cnt_s;
  logic                 in_win, past_win, cur_bit, last_bit;

  // NOTE: combinational block uses blocking assignments with every output given
  // a value on every path, so no latch is inferred.
  always_comb begin
    len_c = (load_len > 5'd16) ? 5'd16 : load_len;
    if (trim < -4'sd4)     trim_c = -4'sd4;
    else if (trim > 4'sd4) trim_c = 4'sd4;
    else                   trim_c = trim;
    offset   = WW'(3 * int'(trim_c));
    cnt_s    = signed'(WW'(cnt));
    in_win   = (cnt_s >= es) && (cnt_s <= ee);
    past_win = (cnt_s > ee);
    cur_bit  = data[bit_idx[3:0]];
    last_bit = (bit_idx == len - 5'd1);
  end

  assign load_ready = (state == IDLE) && en;
  assign busy       = (state != IDLE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      asw_out   <= 1'b0;
      done      <= 1'b0;
      short_pkt <= 1'b0;
      bit_idx   <= '0;
      cnt       <= '0;
      data      <= '0;
      len       <= '0;
      es        <= '0;
      ee        <= '0;
    end else begin
      done      <= 1'b0;
      short_pkt <= 1'b0;
      asw_out   <= 1'b0;
      if (!en) begin
        state   <= IDLE;
        cnt     <= '0;
        bit_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load_valid) begin
              data    <= load_data;
              len     <= len_c;
              es      <= signed'(WW'(WIN_START)) + offset;
              ee      <= signed'(WW'(WIN_STOP)) + offset;
              bit_idx <= '0;
              cnt     <= '0;
              if (len_c == 5'd0) done  <= 1'b1;
              else               state <= WAIT_GAP;
            end
          end
          WAIT_GAP: begin
            if (!dec_in) state <= WAIT_PKT;
          end
          WAIT_PKT: begin
            // The rising cycle itself is count 0 (cnt still holds 0 here).
            if (dec_in) begin
              state   <= IN_PKT;
              cnt     <= CNT_W'(1);
              asw_out <= cur_bit & in_win;
            end
          end
          IN_PKT: begin
            if (dec_in) begin
              if (cnt != '1) cnt <= cnt + 1'b1;
              asw_out <= cur_bit & in_win;
            end else begin
              cnt   <= '0;
              state <= WAIT_PKT;
              if (past_win) begin
                if (last_bit) begin
                  done  <= 1'b1;
                  state <= IDLE;
                end else begin
                  bit_idx <= bit_idx + 5'd1;
                end
              end else begin
                short_pkt <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_backscatter_scheduler.sv
// Directed bench for backscatter_scheduler: per-packet expectations are queued
// before each envelope is driven and compared once the packet has played out.
module tb_backscatter_scheduler;

  logic              clk = 1'b0;
  logic              rst, en, dec_in, load_valid;
  logic              load_ready, asw_out, busy, done, short_pkt;
  logic [15:0]       load_data;
  logic [4:0]        load_len, bit_idx;
  logic signed [3:0] trim;

  int total = 0;
  int bad   = 0;

  // first: cycles from the DEC_IN rise until ASW_OUT is first seen high (0 = never)
  typedef struct {
    int first;
    int nhigh;
    int ndone;
    int nshort;
  } pkt_exp_t;

  pkt_exp_t sb[$];

  backscatter_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .dec_in     (dec_in),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .trim       (trim),
    .asw_out    (asw_out),
    .busy       (busy),
    .bit_idx    (bit_idx),
    .done       (done),
    .short_pkt  (short_pkt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void expect_pkt(input int f, input int n, input int d, input int s);
    pkt_exp_t e;
    e = '{first: f, nhigh: n, ndone: d, nshort: s};
    sb.push_back(e);
  endfunction

  // Offer one job; leaves DEC_IN alone and allows one extra cycle so WAIT_GAP can settle.
  task automatic do_load(input logic [15:0] d, input logic [4:0] l, input logic signed [3:0] t);
    load_data  = d;
    load_len   = l;
    trim       = t;
    load_valid = 1'b1;
    check("load_ready", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    @(negedge clk);
  endtask

  // Drive one envelope of hi cycles followed by gap low cycles, then score it.
  task automatic run_pkt(input string tag, input int hi, input int gap);
    pkt_exp_t e;
    int first = 0, nh = 0, nd = 0, ns = 0;
    for (int i = 0; i < hi + gap; i++) begin
      dec_in = (i < hi);
      @(negedge clk);
      if (asw_out === 1'b1) begin
        nh++;
        if (first == 0) first = i + 1;
      end
      if (done === 1'b1) nd++;
      if (short_pkt === 1'b1) ns++;
      total++;
      assert (!(done === 1'b1 && short_pkt === 1'b1)) else begin
        bad++;
        $error("FAIL %s done_and_short: observed=1 expected=0", tag);
      end
    end
    dec_in = 1'b0;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard_empty: observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " first"},  first, e.first);
      check({tag, " nhigh"},  nh,    e.nhigh);
      check({tag, " done"},   nd,    e.ndone);
      check({tag, " short"},  ns,    e.nshort);
    end
  endtask

  // Kill a '1' bit at count 760 with EN low or RST high.
  task automatic abort_test(input string tag, input bit via_rst);
    int nh = 0, nd = 0;
    for (int i = 0; i <= 760; i++) begin
      dec_in = 1'b1;
      if (i == 760) begin
        if (via_rst) rst = 1'b1;
        else         en  = 1'b0;
      end
      @(negedge clk);
      if (asw_out === 1'b1) nh++;
      if (done === 1'b1) nd++;
    end
    check({tag, " asw_high_before"}, nh, 40);
    check({tag, " asw_after"}, asw_out, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " bit_idx"}, bit_idx, 0);
    if (!via_rst) check({tag, " load_ready_en_low"}, load_ready, 0);
    rst    = 1'b0;
    en     = 1'b1;
    dec_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check({tag, " load_ready"}, load_ready, 1);
    check({tag, " no_done"}, nd, 0);
  endtask

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    dec_in     = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    load_len   = '0;
    trim       = '0;
    repeat (3) @(negedge clk);
    check("rst asw", asw_out, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst short", short_pkt, 0);
    check("rst bit_idx", bit_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle load_ready", load_ready, 1);

    // Three bits 1,0,1: window of 80 cycles opening 721 cycles after the rise.
    do_load(16'h0005, 5'd3, 4'sd0);
    check("job busy", busy, 1);
    expect_pkt(721, 80, 0, 0);
    run_pkt("p1", 900, 50);
    check("p1 bit_idx", bit_idx, 1);
    expect_pkt(0, 0, 0, 0);
    run_pkt("p2", 900, 50);
    expect_pkt(721, 80, 1, 0);
    run_pkt("p3", 900, 50);
    check("p3 busy", busy, 0);

    // Trim shifts the window by 3 counts per step; out-of-range trim clamps.
    do_load(16'h0001, 5'd1, -4'sd4);
    expect_pkt(709, 80, 1, 0);
    run_pkt("trim_m4", 900, 20);
    do_load(16'h0001, 5'd1, 4'sd4);
    expect_pkt(733, 80, 1, 0);
    run_pkt("trim_p4", 900, 20);
    do_load(16'h0001, 5'd1, 4'sd7);
    expect_pkt(733, 80, 1, 0);
    run_pkt("trim_7", 900, 20);

    // Short packet: ASW cut mid-window, bit retried on the next packet.
    do_load(16'h0001, 5'd1, 4'sd0);
    expect_pkt(721, 30, 0, 1);
    run_pkt("short", 750, 20);
    check("short bit_idx", bit_idx, 0);
    check("short busy", busy, 1);
    expect_pkt(721, 80, 1, 0);
    run_pkt("retry", 900, 20);

    // Load while a packet is already running: that packet is skipped.
    dec_in = 1'b1;
    repeat (100) @(negedge clk);
    do_load(16'h0003, 5'd2, 4'sd0);
    expect_pkt(0, 0, 0, 0);
    run_pkt("inflight", 800, 50);
    expect_pkt(721, 80, 0, 0);
    run_pkt("after_inflight", 900, 50);
    check("inflight bit_idx", bit_idx, 1);

    abort_test("abort_en", 1'b0);
    do_load(16'h0001, 5'd1, 4'sd0);
    abort_test("abort_rst", 1'b1);

    // Zero-length job completes immediately without ever going busy.
    load_data  = 16'hFFFF;
    load_len   = 5'd0;
    trim       = 4'sd0;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    check("len0 done", done, 1);
    check("len0 busy", busy, 0);
    check("len0 asw", asw_out, 0);
    @(negedge clk);
    check("len0 done_once", done, 0);
    check("len0 busy_after", busy, 0);

    // Oversized length clamps to 16 bits, LSB first.
    do_load(16'h8001, 5'd31, 4'sd0);
    for (int b = 0; b < 16; b++) begin
      if (b == 0 || b == 15) expect_pkt(721, 80, (b == 15) ? 1 : 0, 0);
      else                   expect_pkt(0, 0, 0, 0);
      run_pkt($sformatf("len16_b%0d", b), 900, 20);
    end
    check("len16 busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
